// File: rtl/button_pio_edge_if.sv
// Avalon-MM slave bus bundle for the button PIO register file.
// The master drives address/strobes/data, and the slave returns registered readdata.
interface button_pio_edge_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/button_pio_edge.sv
// Push-button/switch input PIO with a synchroniser, a per-bit debounce filter,
// write-1-to-clear edge capture, an interrupt mask and a registered level IRQ.
module button_pio_edge #(
   parameter int WIDTH      = 4,
   parameter int DEBOUNCE   = 1,
   parameter int EDGE_TYPE  = 1,
   parameter int INIT_LEVEL = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   button_pio_edge_if.slave   bus,
   input  logic [WIDTH-1:0]   in_port,
   output logic               irq
);

   localparam int CW = ($clog2(DEBOUNCE + 1) < 1) ? 1 : $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0]    CNT_LAST  = CW'(DEBOUNCE - 1);
   localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
   localparam logic [WIDTH-1:0] RST_LEVEL = (INIT_LEVEL != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_db;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_cap;
   logic [CW-1:0]    r_cnt [WIDTH];
   logic [31:0]      r_readdata;
   logic             r_irq;

   logic [WIDTH-1:0] w_db_nxt;
   logic [CW-1:0]    w_cnt_nxt [WIDTH];
   logic [WIDTH-1:0] w_set;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_mask_nxt;
   logic [WIDTH-1:0] w_cap_nxt;
   logic [31:0]      w_rd_nxt;
   logic             w_wr;

   assign w_wr        = bus.chipselect & ~bus.write_n;
   assign bus.readdata = r_readdata;
   assign irq         = r_irq;

   // Debounce filter: accept a new level once it has differed for DEBOUNCE edges.
   always_comb begin
      w_db_nxt = r_db;
      w_set    = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         w_cnt_nxt[i] = r_cnt[i];
         if (r_sync2[i] == r_db[i]) begin
            w_cnt_nxt[i] = {CW{1'b0}};
         end else if (r_cnt[i] == CNT_LAST) begin
            w_db_nxt[i]  = r_sync2[i];
            w_cnt_nxt[i] = {CW{1'b0}};
            case (EDGE_TYPE)
               32'sd0:  w_set[i] = r_sync2[i];
               32'sd1:  w_set[i] = ~r_sync2[i];
               default: w_set[i] = 1'b1;
            endcase
         end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
         end
      end
   end

   // Register writes and the read mux; a capture set takes priority over its clear.
   always_comb begin
      w_mask_nxt = r_mask;
      w_clr      = {WIDTH{1'b0}};
      if (w_wr) begin
         case (bus.address)
            2'd2:    w_mask_nxt = bus.writedata[WIDTH-1:0];
            2'd3:    w_clr      = bus.writedata[WIDTH-1:0];
            default: begin
               w_mask_nxt = r_mask;
               w_clr      = {WIDTH{1'b0}};
            end
         endcase
      end else begin
         w_mask_nxt = r_mask;
         w_clr      = {WIDTH{1'b0}};
      end
      w_cap_nxt = (r_cap & ~w_clr) | w_set;
      case (bus.address)
         2'd0:    w_rd_nxt = 32'(r_db);
         2'd2:    w_rd_nxt = 32'(r_mask);
         2'd3:    w_rd_nxt = 32'(r_cap);
         default: w_rd_nxt = 32'h0000_0000;
      endcase
   end

   // State registers; irq is computed from the registered capture and mask.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1    <= RST_LEVEL;
         r_sync2    <= RST_LEVEL;
         r_db       <= RST_LEVEL;
         r_mask     <= {WIDTH{1'b0}};
         r_cap      <= {WIDTH{1'b0}};
         r_readdata <= 32'h0000_0000;
         r_irq      <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= {CW{1'b0}};
         end
      end else begin
         r_sync1    <= in_port;
         r_sync2    <= r_sync1;
         r_db       <= w_db_nxt;
         r_mask     <= w_mask_nxt;
         r_cap      <= w_cap_nxt;
         r_readdata <= w_rd_nxt;
         r_irq      <= |(r_cap & r_mask);
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_button_pio_edge.sv
// Bench for button_pio_edge: three variants (falling/D=4, any/D=2, rising/D=1)
// share one stimulus stream and are checked against a behavioural model every cycle.
module tb_button_pio_edge;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'h0;
   logic [3:0]  in_port = 4'hF;
   logic        irq_a, irq_b, irq_c;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   button_pio_edge_if bus_a ();
   button_pio_edge_if bus_b ();
   button_pio_edge_if bus_c ();

   assign bus_a.address = address;  assign bus_a.chipselect = chipselect;
   assign bus_a.write_n = write_n;  assign bus_a.writedata  = writedata;
   assign bus_b.address = address;  assign bus_b.chipselect = chipselect;
   assign bus_b.write_n = write_n;  assign bus_b.writedata  = writedata;
   assign bus_c.address = address;  assign bus_c.chipselect = chipselect;
   assign bus_c.write_n = write_n;  assign bus_c.writedata  = writedata;

   button_pio_edge #(.WIDTH(4), .DEBOUNCE(4), .EDGE_TYPE(1), .INIT_LEVEL(1)) u_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a.slave), .in_port(in_port), .irq(irq_a));
   button_pio_edge #(.WIDTH(4), .DEBOUNCE(2), .EDGE_TYPE(2), .INIT_LEVEL(1)) u_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b.slave), .in_port(in_port), .irq(irq_b));
   button_pio_edge #(.WIDTH(4), .DEBOUNCE(1), .EDGE_TYPE(0), .INIT_LEVEL(1)) u_c (
      .clk(clk), .reset_n(reset_n), .bus(bus_c.slave), .in_port(in_port), .irq(irq_c));

   // Behavioural model: per variant, per bit, count how long the synchronised pin
   // has disagreed with the accepted level; accept after DEBOUNCE such edges.
   int          m_deb [3] = '{4, 2, 1};
   int          m_edg [3] = '{1, 2, 0};
   logic [3:0]  m_s1 [3], m_s2 [3], m_db [3], m_mask [3], m_cap [3];
   int          m_run [3][4];
   logic [31:0] m_rd [3];
   logic        m_irq [3];

   task automatic m_reset();
      for (int d = 0; d < 3; d++) begin
         m_s1[d] = 4'hF; m_s2[d] = 4'hF; m_db[d] = 4'hF;
         m_mask[d] = 4'h0; m_cap[d] = 4'h0; m_rd[d] = 32'h0; m_irq[d] = 1'b0;
         for (int b = 0; b < 4; b++) m_run[d][b] = 0;
      end
   endtask

   task automatic m_step();
      logic [3:0] ndb, set, clr;
      bit         wr;
      wr = chipselect && !write_n;
      for (int d = 0; d < 3; d++) begin
         ndb = m_db[d];
         set = 4'h0;
         for (int b = 0; b < 4; b++) begin
            if (m_s2[d][b] != m_db[d][b]) begin
               m_run[d][b] = m_run[d][b] + 1;
               if (m_run[d][b] == m_deb[d]) begin
                  ndb[b] = m_s2[d][b];
                  m_run[d][b] = 0;
                  if (m_edg[d] == 2)      set[b] = 1'b1;
                  else if (m_edg[d] == 0) set[b] = m_s2[d][b];
                  else                    set[b] = !m_s2[d][b];
               end
            end else begin
               m_run[d][b] = 0;
            end
         end
         m_irq[d] = |(m_cap[d] & m_mask[d]);
         case (address)
            2'd0:    m_rd[d] = {28'h0, m_db[d]};
            2'd2:    m_rd[d] = {28'h0, m_mask[d]};
            2'd3:    m_rd[d] = {28'h0, m_cap[d]};
            default: m_rd[d] = 32'h0;
         endcase
         clr = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
         m_cap[d] = (m_cap[d] & ~clr) | set;
         if (wr && address == 2'd2) m_mask[d] = writedata[3:0];
         m_db[d] = ndb;
         m_s2[d] = m_s1[d];
         m_s1[d] = in_port;
      end
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) m_reset();
         else          m_step();
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of all outputs against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         check("model rd_a", bus_a.readdata, m_rd[0]);
         check("model rd_b", bus_b.readdata, m_rd[1]);
         check("model rd_c", bus_c.readdata, m_rd[2]);
         check("model irq_a", 32'(irq_a), 32'(m_irq[0]));
         check("model irq_b", 32'(irq_b), 32'(m_irq[1]));
         check("model irq_c", 32'(irq_c), 32'(m_irq[2]));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
   endtask

   task automatic rd(input logic [1:0] a);
      address = a;
      @(negedge clk);
   endtask

   initial begin
      // Reset values
      cyc(2);
      check("rst rd_a", bus_a.readdata, 32'h0);
      check("rst irq_a", 32'(irq_a), 32'h0);
      reset_n = 1'b1;
      cyc(4);
      rd(2'd0);
      check("init db_a", bus_a.readdata, 32'h0000_000F);
      check("init db_c", bus_c.readdata, 32'h0000_000F);
      rd(2'd3);
      check("init cap_a", bus_a.readdata, 32'h0);
      check("init cap_b", bus_b.readdata, 32'h0);

      // Glitch of 3 cycles must not pass a 4-cycle filter
      wr(2'd2, 32'h1);
      address = 2'd3;
      in_port = 4'hE; cyc(3);
      in_port = 4'hF; cyc(8);
      check("glitch cap_a", bus_a.readdata, 32'h0);
      check("glitch irq_a", 32'(irq_a), 32'h0);
      rd(2'd0);
      check("glitch db_a", bus_a.readdata, 32'h0000_000F);

      // Held low: capture set at edge k+5, visible in readdata/irq one edge later
      address = 2'd3; in_port = 4'hE;
      cyc(6);
      check("lat cap_a early", bus_a.readdata, 32'h0);
      check("lat irq_a early", 32'(irq_a), 32'h0);
      cyc(1);
      check("lat cap_a", bus_a.readdata, 32'h1);
      check("lat irq_a", 32'(irq_a), 32'h1);
      rd(2'd0);
      check("lat db_a", bus_a.readdata, 32'h0000_000E);

      // Mask gating
      wr(2'd3, 32'hF);
      wr(2'd2, 32'h3);
      in_port = 4'hA; cyc(8);
      rd(2'd3);
      check("gate cap_a", bus_a.readdata, 32'h4);
      check("gate irq_a", 32'(irq_a), 32'h0);
      wr(2'd2, 32'h4);
      check("gate irq_a wr", 32'(irq_a), 32'h0);
      cyc(1);
      check("gate irq_a on", 32'(irq_a), 32'h1);

      // Write-1-to-clear
      wr(2'd3, 32'hF);
      wr(2'd2, 32'hF);
      in_port = 4'h0; cyc(8);
      rd(2'd3);
      check("w1c cap_a", bus_a.readdata, 32'hA);
      wr(2'd3, 32'h2);
      rd(2'd3);
      check("w1c cap_a 8", bus_a.readdata, 32'h8);
      check("w1c irq_a", 32'(irq_a), 32'h1);
      wr(2'd3, 32'h8);
      cyc(1);
      check("w1c irq_a off", 32'(irq_a), 32'h0);
      rd(2'd3);
      check("w1c cap_a 0", bus_a.readdata, 32'h0);

      // Set beats clear on the same edge
      in_port = 4'h4; cyc(8);
      wr(2'd3, 32'hF);
      address = 2'd3; in_port = 4'h0;
      cyc(5);
      wr(2'd3, 32'h4);
      rd(2'd3);
      check("sbc cap_a", bus_a.readdata, 32'h4);

      // Edge type selection
      wr(2'd3, 32'hF);
      in_port = 4'h2; cyc(8);
      wr(2'd3, 32'hF);
      in_port = 4'h0; cyc(8);
      rd(2'd3);
      check("fall cap_a", bus_a.readdata, 32'h2);
      check("fall cap_b", bus_b.readdata, 32'h2);
      check("fall cap_c", bus_c.readdata, 32'h0);
      wr(2'd3, 32'hF);
      in_port = 4'h2; cyc(8);
      rd(2'd3);
      check("rise cap_a", bus_a.readdata, 32'h0);
      check("rise cap_b", bus_b.readdata, 32'h2);
      check("rise cap_c", bus_c.readdata, 32'h2);

      // Asynchronous reset in the middle of a debounce count
      wr(2'd3, 32'hF);
      address = 2'd0; in_port = 4'h0;
      cyc(3);
      check("pre-rst db_a", bus_a.readdata, 32'h2);
      #2 reset_n = 1'b0;
      #1;
      check("async rd_a", bus_a.readdata, 32'h0);
      check("async rd_b", bus_b.readdata, 32'h0);
      check("async rd_c", bus_c.readdata, 32'h0);
      check("async irq_b", 32'(irq_b), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(1);
      check("post-rst db_a", bus_a.readdata, 32'h0000_000F);
      cyc(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
